stack_cpu_sequencer: RTL and testbench

STACK_CPU_SEQUENCER -- requirements
Module: stack_cpu_sequencer

---
 rtl/stack_cpu_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_stack_cpu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_sequencer.sv
// Stack CPU control sequencer: fetches 16-bit instructions and drives an
// external operand stack and ALU through pop/operate/push micro-steps.
module stack_cpu_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 16,
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic [PC_WIDTH-1:0]            pc,
    output logic                           imem_rd,
    input  logic [INSTR_WIDTH-1:0]         instr,
    output logic                           stk_push,
    output logic                           stk_pop,
    output logic [DATA_WIDTH-1:0]          stk_wdata,
    input  logic [DATA_WIDTH-1:0]          stk_rdata,
    input  logic                           stk_full,
    input  logic [$clog2(STACK_DEPTH):0]   stk_count,
    output logic [4:0]                     alu_op,
    output logic [DATA_WIDTH-1:0]          alu_a,
    output logic [DATA_WIDTH-1:0]          alu_b,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    output logic                           halted,
    output logic                           error,
    output logic [1:0]                     err_code
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    localparam logic [4:0] OP_PUSH = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_MOD  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_INV  = 5'd8;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_POP2,
        S_POP1, S_PUSH, S_HALT, S_ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [4:0]             op_q, op_d;
    logic [10:0]            imm_q, imm_d;
    logic [4:0]             alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]  alu_b_q, alu_b_d;
    logic                   halted_q, halted_d;
    logic                   error_q, error_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [4:0]             dec_op;
    logic                   div_zero;
    logic [DATA_WIDTH-1:0]  imm_ext;

    assign dec_op   = instr[15:11];
    assign imm_ext  = {{(DATA_WIDTH-11){imm_q[10]}}, imm_q};
    assign div_zero = ((op_q == OP_DIV) || (op_q == OP_MOD)) &&
                      (stk_rdata == '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        imm_d      = imm_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        halted_d   = halted_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d     = dec_op;
                imm_d    = instr[10:0];
                alu_op_d = dec_op;
                case (dec_op)
                    OP_PUSH: begin
                        if (stk_full) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'b10;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                    OP_MOD, OP_AND, OP_OR: begin
                        if (stk_count < CW'(2)) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            state_d = S_POP2;
                        end
                    end
                    OP_INV: begin
                        if (stk_count == '0) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            state_d = S_POP1;
                        end
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'b11;
                    end
                endcase
            end
            // Divisor is checked before anything leaves the stack.
            S_POP2: begin
                if (div_zero) begin
                    state_d    = S_ERROR;
                    error_d    = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    alu_b_d = stk_rdata;
                    state_d = S_POP1;
                end
            end
            S_POP1: begin
                alu_a_d = stk_rdata;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            op_q       <= '0;
            imm_q      <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign imem_rd   = (state_q == S_FETCH);
    assign stk_pop   = ((state_q == S_POP2) && !div_zero) ||
                       (state_q == S_POP1);
    assign stk_push  = (state_q == S_PUSH);
    assign stk_wdata = (op_q == OP_PUSH) ? imm_ext : alu_result;
    assign pc        = pc_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign halted    = halted_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Bench for stack_cpu_sequencer: behavioural imem, stack and ALU around the
// DUT, a push-data scoreboard and a table of short programs.
module tb_stack_cpu_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [7:0]  pc;
    logic        imem_rd;
    logic [15:0] instr = '0;
    logic        stk_push, stk_pop;
    logic [31:0] stk_wdata, stk_rdata;
    logic        stk_full;
    logic [4:0]  stk_count;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        halted, error;
    logic [1:0]  err_code;

    stack_cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
        .imem_rd(imem_rd), .instr(instr), .stk_push(stk_push),
        .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
        .stk_full(stk_full), .stk_count(stk_count), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .halted(halted), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op,
                                        input logic [10:0] imm);
        return {op, imm};
    endfunction

    logic [15:0] imem [256];
    always @(posedge clk) if (imem_rd) instr <= imem[pc];

    // Operand stack model, preloaded with 1,2,3.. while in reset
    int          pre_n = 0;
    logic [31:0] smem [16];
    int          scnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            scnt <= pre_n;
            for (int i = 0; i < 16; i++) smem[i] <= 32'(i + 1);
        end else if (stk_push && scnt < 16) begin
            smem[scnt] <= stk_wdata;
            scnt <= scnt + 1;
        end else if (stk_pop && scnt > 0) begin
            scnt <= scnt - 1;
        end
    end
    always_comb begin
        stk_rdata = (scnt > 0) ? smem[scnt-1] : 32'h0;
        stk_full  = (scnt == 16);
        stk_count = scnt[4:0];
    end

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            5'd1: alu_result = alu_a + alu_b;
            5'd2: alu_result = alu_a - alu_b;
            5'd3: alu_result = alu_a * alu_b;
            5'd4: alu_result = (alu_b != 0) ? alu_a / alu_b : 32'h0;
            5'd5: alu_result = (alu_b != 0) ? alu_a % alu_b : 32'h0;
            5'd6: alu_result = alu_a & alu_b;
            5'd7: alu_result = alu_a | alu_b;
            5'd8: alu_result = ~alu_a;
            default: alu_result = 32'h0;
        endcase
    end

    logic [31:0] sbq [$];
    int pop_cnt = 0;
    int fetch_cnt = 0;
    always @(negedge clk) begin
        int n;
        n = int'(imem_rd) + int'(stk_push) + int'(stk_pop);
        if (n != 0) chk("strobe_excl", 32'(n), 32'd1);
        if (stk_pop) pop_cnt++;
        if (imem_rd) fetch_cnt++;
        if (stk_push) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL push_unexpected actual=%h required=none",
                         stk_wdata);
            end else begin
                chk("push_data", stk_wdata, sbq.pop_front());
            end
        end
    end

    typedef struct {
        logic [0:3][15:0] prog;
        int               np;
        int               pre;
        logic             h;
        logic             e;
        logic [1:0]       code;
        logic [7:0]       pcx;
        int               cnt;
        int               pops;
        logic [0:3][31:0] pushes;
        int               npush;
        logic             ab;
        logic [31:0]      a;
        logic [31:0]      b;
    } vec_t;

    function automatic vec_t mk(
        input logic [0:3][15:0] prog, input int np, input int pre,
        input logic h, input logic e, input logic [1:0] code,
        input logic [7:0] pcx, input int cnt, input int pops,
        input logic [0:3][31:0] pushes, input int npush,
        input logic ab, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.prog = prog; v.np = np; v.pre = pre; v.h = h; v.e = e;
        v.code = code; v.pcx = pcx; v.cnt = cnt; v.pops = pops;
        v.pushes = pushes; v.npush = npush; v.ab = ab; v.a = a; v.b = b;
        return v;
    endfunction

    localparam logic [15:0] HLT = 16'hF800;

    task automatic do_reset(input int pre);
        pre_n = pre;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic pulse_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c;
        c = 0;
        while (!(halted || error) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!(halted || error)) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        string s;
        int p0, f0;
        s = $sformatf("v%0d", k);
        for (int i = 0; i < 256; i++) imem[i] = HLT;
        for (int i = 0; i < v.np; i++) imem[i] = v.prog[i];
        do_reset(v.pre);
        sbq.delete();
        for (int i = 0; i < v.npush; i++) sbq.push_back(v.pushes[i]);
        p0 = pop_cnt;
        pulse_start();
        wait_done(s, 200);
        chk({s, "_halted"}, 32'(halted), 32'(v.h));
        chk({s, "_error"}, 32'(error), 32'(v.e));
        chk({s, "_errcode"}, 32'(err_code), 32'(v.code));
        chk({s, "_pc"}, 32'(pc), 32'(v.pcx));
        chk({s, "_count"}, 32'(scnt), 32'(v.cnt));
        chk({s, "_pops"}, 32'(pop_cnt - p0), 32'(v.pops));
        chk({s, "_sb_left"}, 32'(sbq.size()), 32'd0);
        if (v.ab) begin
            chk({s, "_alu_a"}, alu_a, v.a);
            chk({s, "_alu_b"}, alu_b, v.b);
        end
        f0 = fetch_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        chk({s, "_ign_fetch"}, 32'(fetch_cnt - f0), 32'd0);
        chk({s, "_ign_flags"}, {28'd0, halted, error, err_code},
            {28'd0, v.h, v.e, v.code});
    endtask

    vec_t tv [10];

    initial begin
        tv[0] = mk({ins(0, 5), ins(0, 3), ins(2, 0), HLT}, 4, 0,
                   1, 0, 2'b00, 8'd3, 1, 2, {32'd5, 32'd3, 32'd2, 32'd0},
                   3, 1, 32'd5, 32'd3);
        tv[1] = mk({ins(1, 0), HLT, HLT, HLT}, 1, 1,
                   0, 1, 2'b01, 8'd0, 1, 0, '0, 0, 0, 0, 0);
        tv[2] = mk({ins(0, 9), HLT, HLT, HLT}, 1, 16,
                   0, 1, 2'b10, 8'd0, 16, 0, '0, 0, 0, 0, 0);
        tv[3] = mk({ins(0, 7), ins(0, 0), ins(4, 0), HLT}, 3, 0,
                   0, 1, 2'b11, 8'd2, 2, 0, {32'd7, 32'd0, 32'd0, 32'd0},
                   2, 0, 0, 0);
        tv[4] = mk({ins(5'h10, 0), HLT, HLT, HLT}, 1, 0,
                   0, 1, 2'b11, 8'd0, 0, 0, '0, 0, 0, 0, 0);
        tv[5] = mk({ins(0, 11'h7FC), ins(0, 3), ins(3, 0), HLT}, 4, 0,
                   1, 0, 2'b00, 8'd3, 1, 2,
                   {32'hFFFF_FFFC, 32'd3, 32'hFFFF_FFF4, 32'd0},
                   3, 1, 32'hFFFF_FFFC, 32'd3);
        tv[6] = mk({ins(0, 17), ins(0, 5), ins(5, 0), HLT}, 4, 0,
                   1, 0, 2'b00, 8'd3, 1, 2, {32'd17, 32'd5, 32'd2, 32'd0},
                   3, 1, 32'd17, 32'd5);
        tv[7] = mk({ins(7, 0), ins(0, 6), ins(6, 0), HLT}, 4, 2,
                   1, 0, 2'b00, 8'd3, 1, 4, {32'd3, 32'd6, 32'd2, 32'd0},
                   3, 1, 32'd3, 32'd6);
        tv[8] = mk({ins(8, 0), HLT, HLT, HLT}, 1, 0,
                   0, 1, 2'b01, 8'd0, 0, 0, '0, 0, 0, 0, 0);
        tv[9] = mk({ins(0, 20), ins(0, 4), ins(4, 0), HLT}, 4, 0,
                   1, 0, 2'b00, 8'd3, 1, 2, {32'd20, 32'd4, 32'd5, 32'd0},
                   3, 1, 32'd20, 32'd4);

        for (int i = 0; i < 256; i++) imem[i] = HLT;
        do_reset(0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_flags", {27'd0, halted, error, err_code, imem_rd},
            32'd0);
        chk("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        chk("rst_alu", alu_a | alu_b | 32'(alu_op), 32'd0);

        for (int k = 0; k < 10; k++) run_vec(k, tv[k]);

        // Sign extension then INVERT of the all-ones value
        for (int i = 0; i < 256; i++) imem[i] = HLT;
        imem[0] = ins(0, 11'h7FF);
        imem[1] = ins(8, 0);
        do_reset(0);
        sbq.delete();
        sbq.push_back(32'hFFFF_FFFF);
        sbq.push_back(32'h0);
        pulse_start();
        wait_done("sext", 100);
        chk("sext_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("sext_halt", 32'(halted), 32'd1);
        chk("sext_sb_left", 32'(sbq.size()), 32'd0);

        // Reset while the second operand is being popped
        for (int i = 0; i < 256; i++) imem[i] = HLT;
        imem[0] = ins(0, 5);
        imem[1] = ins(0, 3);
        imem[2] = ins(1, 0);
        do_reset(0);
        sbq.delete();
        sbq.push_back(32'd5);
        sbq.push_back(32'd3);
        pulse_start();
        begin
            int c;
            c = 0;
            while (!stk_pop && c < 50) begin
                @(negedge clk);
                c++;
            end
            chk("midrst_pop2_seen", 32'(stk_pop), 32'd1);
        end
        @(negedge clk);
        chk("midrst_pop1", 32'(stk_pop), 32'd1);
        chk("midrst_alu_b", alu_b, 32'd3);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_strobes", {29'd0, imem_rd, stk_push, stk_pop}, 32'd0);
        chk("midrst_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("midrst_idle", 32'(fetch_cnt != 0 && imem_rd), 32'd0);
        chk("midrst_sb_left", 32'(sbq.size()), 32'd0);

        // PC wrap: PUSH 1 then 255 INVERTs, then HALT at address 0
        imem[0] = ins(0, 1);
        for (int i = 1; i < 256; i++) imem[i] = ins(8, 0);
        do_reset(0);
        sbq.delete();
        sbq.push_back(32'd1);
        for (int k = 1; k < 256; k++)
            sbq.push_back((k % 2 == 1) ? 32'hFFFF_FFFE : 32'd1);
        pulse_start();
        begin
            int c;
            c = 0;
            while (pc != 8'd1 && c < 50) begin
                @(negedge clk);
                c++;
            end
            chk("wrap_pc1", 32'(pc), 32'd1);
        end
        imem[0] = HLT;
        wait_done("wrap", 3000);
        chk("wrap_halt", 32'(halted), 32'd1);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_count", 32'(scnt), 32'd1);
        chk("wrap_sb_left", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
